vgacon_cellram: RTL and testbench
=================================

// Module: vgacon_cellram
// PURPOSE
//  Text/attribute cell store for the VGA console, generalised: CELL_W-bit cells, byte-lane
//  writes, COLS x ROWS geometry, hardware scroll via a row base offset, built-in clear engine.
//  Sits between the picosoc bus adapter (sys port) and the character generator (vid port).
//  Single clock domain: sys and video sides share clk.
// PARAMETERS
//  COLS    80       characters per row
//  ROWS    30       rows; CELLS = COLS*ROWS, need not be a power of two
//  CELL_W  16       bits per cell (char[7:0], attr[15:8]); multiple of 8
//  ADDR_W  13       cell address width; require CELLS <= 2**ADDR_W
//  BLANK   16'h0720 fill value for clear/scroll (space, grey on black)
// PORTS
//  clk         in   1         system/video clock
//  resetn      in   1         reset, asynchronous, active-low
//  sys_valid   in   1         access request
//  sys_ready   out  1         request accepted when valid&ready
//  sys_we      in   1         1=write, 0=read
//  sys_addr    in   ADDR_W    logical cell index (row*COLS+col)
//  sys_wdata   in   CELL_W    write data
//  sys_wstrb   in   CELL_W/8  byte-lane enables
//  sys_rdata   out  CELL_W    read data, valid when sys_rvalid
//  sys_rvalid  out  1         read response strobe
//  cmd_clear   in   1         pulse: fill all cells with BLANK, base<=0
//  cmd_scroll  in   1         pulse: scroll up one row, blank new bottom row
//  busy        out  1         clear/scroll engine active
//  vid_addr    in   ADDR_W    logical cell index from character generator
//  vid_data    out  CELL_W    cell data, 2 cycles after vid_addr
// BEHAVIOUR
//  - Reset: state IDLE, base=0, busy=0, sys_ready=1, sys_rvalid=0, sys_rdata=0, vid_data=0.
//    RAM contents not reset. Reset mid-operation aborts the engine; partial fill stays.
//  - Translation: phys = addr+base; if phys>=CELLS then phys-=CELLS. base is always a
//    multiple of COLS in [0,CELLS). Applies to sys and vid ports.
//  - Out of range (addr>=CELLS): writes dropped; reads return BLANK with normal timing.
//  - sys_ready = (state==IDLE). Write: lanes with wstrb=1 updated, visible to a read
//    accepted the next cycle. Read: sys_rvalid pulses 1 cycle, 2 cycles after accept.
//  - Video path: stage1 registers translated address, stage2 registers RAM output;
//    latency exactly 2 cycles, never stalls, unaffected by busy.
//  - Video read of a cell written in the same cycle returns old data (read-before-write).
//  - FSM: IDLE -> CLEAR on cmd_clear (cnt=0; writes phys cnt for cnt=0..CELLS-1, one per
//    cycle; base<=0 on entry) -> IDLE after CELLS cycles.
//    IDLE -> SCROLL on cmd_scroll: base<=base+COLS (wrap at CELLS); writes BLANK to old
//    physical row base..base+COLS-1 (new logical last row), COLS cycles -> IDLE.
//  - busy = (state!=IDLE); asserts cycle after command, deasserts cycle after last fill.
//  - cmd_clear and cmd_scroll same cycle: clear wins, scroll dropped.
//    Commands while busy ignored (not queued).
//  - sys write accepted in same cycle as command: completes with pre-command base.
//  - Fill writes use all byte lanes; engine owns the write port while busy.
// STRUCTURE
//  - vgacon_defs.vh (shared include): state encodings (IDLE/CLEAR/SCROLL), default BLANK,
//    cell field positions (CHAR_LSB/ATTR_LSB) for the character generator.
//  - Sub-module vgacon_dpram: port A write (byte strobes)/read, port B read-only,
//    synchronous, inferable as BRAM. Translation, FSM, counters in vgacon_cellram.
// TESTING
//  1 reset, write addr 0 = 16'h1F41 wstrb 2'b11, read 0 -> rdata 16'h1F41, rvalid 2 cyc.
//  2 write 16'hAAAA then 16'h5555 wstrb 2'b01 to addr 5 -> reads 16'hAA55.
//  3 cmd_clear -> busy 2400 cycles, sys_ready=0; then read 0/2399 -> 16'h0720.
//  4 cell 80 = 16'h0142, cmd_scroll -> busy 80 cycles; vid_addr 0 -> 16'h0142 after
//    2 cycles; vid_addr 2320..2399 -> 16'h0720.
//  5 30x cmd_scroll (each after idle) -> base wraps to 0; logical 5 = physical 5.
//  6 cmd_clear+cmd_scroll same cycle -> 2400-cycle clear only, base=0; resetn low at
//    cycle 100 of clear -> busy=0 at once, sys_ready=1; read addr>=2400 -> 16'h0720.

Source files
------------

// File: rtl/vgacon_cellram_pkg.sv
// Shared definitions for the VGA console cell store.
//   state_t           engine states (IDLE / CLEAR / SCROLL)
//   BLANK_DEFAULT     fill cell: space character, grey on black
//   CHAR_LSB/ATTR_LSB cell field positions used by the character generator
//   addr_bits()       index width needed for a memory of n entries
package vgacon_cellram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    localparam logic [15:0] BLANK_DEFAULT = 16'h0720;

    localparam int CHAR_LSB = 0;
    localparam int CHAR_W   = 8;
    localparam int ATTR_LSB = 8;
    localparam int ATTR_W   = 8;

    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vgacon_cellram_if.sv
// System-side access bus between the picosoc bus adapter and the cell store.
//   sys_valid/sys_ready  request handshake (accepted when both high)
//   sys_we               1 = write, 0 = read
//   sys_addr             logical cell index (row*COLS + col)
//   sys_wdata/sys_wstrb  write data and byte-lane enables
//   sys_rdata/sys_rvalid read data and its one-cycle strobe
interface vgacon_cellram_if #(
    parameter int ADDR_W = 13,
    parameter int CELL_W = 16
) ();
    logic                  sys_valid;
    logic                  sys_ready;
    logic                  sys_we;
    logic [ADDR_W-1:0]     sys_addr;
    logic [CELL_W-1:0]     sys_wdata;
    logic [CELL_W/8-1:0]   sys_wstrb;
    logic [CELL_W-1:0]     sys_rdata;
    logic                  sys_rvalid;

    modport master (
        output sys_valid, sys_we, sys_addr, sys_wdata, sys_wstrb,
        input  sys_ready, sys_rdata, sys_rvalid
    );

    modport slave (
        input  sys_valid, sys_we, sys_addr, sys_wdata, sys_wstrb,
        output sys_ready, sys_rdata, sys_rvalid
    );
endinterface

// File: rtl/vgacon_cellram_dpram.sv
// Dual-port synchronous cell RAM, inferable as block RAM.
//   i_clk, i_rst_n   clock; active-low async reset (read registers only)
//   port A           i_a_we/i_a_strb/i_a_addr/i_a_wdata byte-lane write,
//                    o_a_rdata registered read (read-before-write)
//   port B           i_b_addr -> o_b_rdata registered read-only
module vgacon_cellram_dpram #(
    parameter int DEPTH  = 2400,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_a_we,
    input  logic [DATA_W/8-1:0]  i_a_strb,
    input  logic [ADDR_W-1:0]    i_a_addr,
    input  logic [DATA_W-1:0]    i_a_wdata,
    output logic [DATA_W-1:0]    o_a_rdata,
    input  logic [ADDR_W-1:0]    i_b_addr,
    output logic [DATA_W-1:0]    o_b_rdata
);
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    always_ff @(posedge i_clk) begin
        if (i_a_we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (i_a_strb[i]) r_mem[i_a_addr][i*8 +: 8] <= i_a_wdata[i*8 +: 8];
            end
        end
    end

    // Both read registers sample the old contents when a write hits the same cell.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_a_rdata <= r_mem[i_a_addr];
            r_b_rdata <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;
endmodule

// File: rtl/vgacon_cellram.sv
// Text/attribute cell store for the VGA console with hardware scroll and clear engine.
//   clk, resetn            shared sys/video clock; async active-low reset
//   sys                    bus port (vgacon_cellram_if.slave)
//   cmd_clear, cmd_scroll  one-cycle command pulses (clear wins when both)
//   busy                   clear/scroll engine active
//   vid_addr -> vid_data   character-generator read, fixed 2-cycle latency
module vgacon_cellram
    import vgacon_cellram_pkg::*;
#(
    parameter int                COLS   = 80,
    parameter int                ROWS   = 30,
    parameter int                CELL_W = 16,
    parameter int                ADDR_W = 13,
    parameter logic [CELL_W-1:0] BLANK  = CELL_W'(BLANK_DEFAULT)
) (
    input  logic               clk,
    input  logic               resetn,
    vgacon_cellram_if.slave    sys,
    input  logic               cmd_clear,
    input  logic               cmd_scroll,
    output logic               busy,
    input  logic [ADDR_W-1:0]  vid_addr,
    output logic [CELL_W-1:0]  vid_data
);
    localparam int              CELLS      = COLS * ROWS;
    localparam int              AW         = addr_bits(CELLS);
    localparam int              NB         = CELL_W / 8;
    localparam logic [AW:0]     CELLS_X    = (AW+1)'(CELLS);
    localparam logic [ADDR_W:0] CELLS_L    = (ADDR_W+1)'(CELLS);
    localparam logic [AW-1:0]   LAST_CELL  = AW'(CELLS - 1);
    localparam logic [AW-1:0]   LAST_COL   = AW'(COLS - 1);
    localparam logic [AW-1:0]   COLS_A     = AW'(COLS);

    // Logical-to-physical: add the row base and wrap once (both operands < CELLS).
    function automatic logic [AW-1:0] to_phys(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= CELLS_X) s = s - CELLS_X;
        return AW'(s);
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_base;
    logic [AW-1:0]       r_cnt;
    logic [AW-1:0]       r_fill_start;
    logic                w_busy;
    logic                w_ready;
    logic                w_fill;

    logic                w_sys_inrange;
    logic [AW-1:0]       w_sys_phys;
    logic                w_rd_acc;
    logic                w_a_we;
    logic [AW-1:0]       w_a_addr;
    logic [CELL_W-1:0]   w_a_wdata;
    logic [NB-1:0]       w_a_strb;
    logic [CELL_W-1:0]   w_a_rdata;
    logic [CELL_W-1:0]   w_b_rdata;

    logic                r_rd_vld_p1;
    logic                r_rd_oor_p1;
    logic                r_rvalid;
    logic [CELL_W-1:0]   r_rdata;

    logic                w_vid_inrange;
    logic [AW-1:0]       r_vid_addr_p1;
    logic                r_vid_oor_p1;
    logic                r_vid_oor_p2;

    // ---------------- engine FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_clear)       w_state_nxt = ST_CLEAR;
                else if (cmd_scroll) w_state_nxt = ST_SCROLL;
            end
            ST_CLEAR:  if (r_cnt == LAST_CELL) w_state_nxt = ST_IDLE;
            ST_SCROLL: if (r_cnt == LAST_COL)  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state != ST_IDLE);
        w_ready = (r_state == ST_IDLE);
        w_fill  = (r_state == ST_CLEAR) || (r_state == ST_SCROLL);
    end

    // Scroll blanks the old top physical row, which becomes the new logical bottom row.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_base       <= '0;
            r_cnt        <= '0;
            r_fill_start <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
            if (cmd_clear) begin
                r_base       <= '0;
                r_fill_start <= '0;
            end else if (cmd_scroll) begin
                r_fill_start <= r_base;
                r_base       <= to_phys(r_base, COLS_A);
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ---------------- port A: sys access / fill ----------------
    assign w_sys_inrange = {1'b0, sys.sys_addr} < CELLS_L;
    assign w_sys_phys    = w_sys_inrange ? to_phys(AW'(sys.sys_addr), r_base) : '0;
    assign w_rd_acc      = sys.sys_valid & w_ready & ~sys.sys_we;

    always_comb begin
        w_a_we    = sys.sys_valid & w_ready & sys.sys_we & w_sys_inrange;
        w_a_addr  = w_sys_phys;
        w_a_wdata = sys.sys_wdata;
        w_a_strb  = sys.sys_wstrb;
        if (w_fill) begin
            w_a_we    = 1'b1;
            w_a_addr  = r_fill_start + r_cnt;
            w_a_wdata = BLANK;
            w_a_strb  = '1;
        end
    end

    vgacon_cellram_dpram #(
        .DEPTH  (CELLS),
        .ADDR_W (AW),
        .DATA_W (CELL_W)
    ) u_ram (
        .i_clk     (clk),
        .i_rst_n   (resetn),
        .i_a_we    (w_a_we),
        .i_a_strb  (w_a_strb),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (w_a_wdata),
        .o_a_rdata (w_a_rdata),
        .i_b_addr  (r_vid_addr_p1),
        .o_b_rdata (w_b_rdata)
    );

    // ---------------- sys read: p1 = RAM read, p2 = response ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_vld_p1 <= 1'b0;
            r_rd_oor_p1 <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rd_vld_p1 <= w_rd_acc;
            r_rd_oor_p1 <= ~w_sys_inrange;
            r_rvalid    <= r_rd_vld_p1;
            if (r_rd_vld_p1) r_rdata <= r_rd_oor_p1 ? BLANK : w_a_rdata;
        end
    end

    assign sys.sys_ready  = w_ready;
    assign sys.sys_rvalid = r_rvalid;
    assign sys.sys_rdata  = r_rdata;
    assign busy           = w_busy;

    // ---------------- video: p1 = translated address, p2 = RAM output ----------------
    assign w_vid_inrange = {1'b0, vid_addr} < CELLS_L;

    always_ff @(posedge clk) begin
        r_vid_addr_p1 <= w_vid_inrange ? to_phys(AW'(vid_addr), r_base) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vid_oor_p1 <= 1'b0;
            r_vid_oor_p2 <= 1'b0;
        end else begin
            r_vid_oor_p1 <= ~w_vid_inrange;
            r_vid_oor_p2 <= r_vid_oor_p1;
        end
    end

    assign vid_data = r_vid_oor_p2 ? BLANK : w_b_rdata;
endmodule

// File: tb/tb_vgacon_cellram.sv
module tb_vgacon_cellram;
    localparam int          COLS  = 80;
    localparam int          ROWS  = 30;
    localparam int          CELLS = COLS * ROWS;
    localparam logic [15:0] BLANK = 16'h0720;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_clear = 1'b0;
    logic        cmd_scroll = 1'b0;
    logic        busy;
    logic [12:0] vid_addr = '0;
    logic [15:0] vid_data;

    always #5 clk = ~clk;

    vgacon_cellram_if #(.ADDR_W(13), .CELL_W(16)) sys ();

    vgacon_cellram dut (
        .clk        (clk),
        .resetn     (resetn),
        .sys        (sys),
        .cmd_clear  (cmd_clear),
        .cmd_scroll (cmd_scroll),
        .busy       (busy),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: the screen as the software sees it (logical cell order).
    logic [15:0] scr   [0:CELLS-1];
    bit          known [0:CELLS-1];

    function automatic void m_write(input int a, input logic [15:0] d, input logic [1:0] s);
        if (a >= CELLS) return;
        if (s[0]) scr[a][7:0]  = d[7:0];
        if (s[1]) scr[a][15:8] = d[15:8];
        if (s == 2'b11) known[a] = 1'b1;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < CELLS; i++) begin
            scr[i] = BLANK;
            known[i] = 1'b1;
        end
    endfunction

    function automatic void m_scroll();
        for (int i = 0; i < CELLS - COLS; i++) begin
            scr[i] = scr[i + COLS];
            known[i] = known[i + COLS];
        end
        for (int i = CELLS - COLS; i < CELLS; i++) begin
            scr[i] = BLANK;
            known[i] = 1'b1;
        end
    endfunction

    function automatic logic [15:0] m_read(input int a);
        if (a >= CELLS) return BLANK;
        return scr[a];
    endfunction

    function automatic bit m_known(input int a);
        if (a >= CELLS) return 1'b1;
        return known[a];
    endfunction

    // ---------------- drivers ----------------
    task automatic do_write(input int a, input logic [15:0] d, input logic [1:0] s);
        @(negedge clk);
        sys.sys_valid = 1'b1; sys.sys_we = 1'b1; sys.sys_addr = 13'(a);
        sys.sys_wdata = d; sys.sys_wstrb = s;
        @(negedge clk);
        sys.sys_valid = 1'b0; sys.sys_we = 1'b0;
        m_write(a, d, s);
    endtask

    task automatic do_read(input int a, output logic rv1, output logic rv2,
                           output logic rv3, output logic [15:0] d);
        @(negedge clk);
        sys.sys_valid = 1'b1; sys.sys_we = 1'b0; sys.sys_addr = 13'(a);
        @(negedge clk);
        sys.sys_valid = 1'b0;
        rv1 = sys.sys_rvalid;
        @(negedge clk);
        rv2 = sys.sys_rvalid;
        d   = sys.sys_rdata;
        @(negedge clk);
        rv3 = sys.sys_rvalid;
    endtask

    task automatic vid_read(input int a, output logic [15:0] d);
        @(negedge clk);
        vid_addr = 13'(a);
        @(negedge clk);
        @(negedge clk);
        d = vid_data;
    endtask

    task automatic pulse_cmd(input logic c, input logic s);
        @(negedge clk);
        cmd_clear = c; cmd_scroll = s;
        @(negedge clk);
        cmd_clear = 1'b0; cmd_scroll = 1'b0;
    endtask

    // Counts busy cycles from the negedge after a command; optionally pulses cmd_clear
    // once while busy to confirm it is ignored.
    task automatic count_busy(input int inject_at, output int n, output bit ready_bad);
        n = 0;
        ready_bad = 1'b0;
        while (busy && n < 5000) begin
            if (sys.sys_ready) ready_bad = 1'b1;
            cmd_clear = (n == inject_at);
            n++;
            @(negedge clk);
        end
        cmd_clear = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (sys.sys_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", sys.sys_ready); end
        checks++; if (sys.sys_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", sys.sys_rvalid); end
        checks++; if (sys.sys_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", sys.sys_rdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (vid_data !== 16'h0) begin failures++; $display("FAIL reset_vid_data got=%h exp=0000", vid_data); end
        resetn = 1'b1;
    endtask

    task automatic test_write_read();
        logic rv1, rv2, rv3; logic [15:0] d;
        do_write(0, 16'h1F41, 2'b11);
        do_read(0, rv1, rv2, rv3, d);
        checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL rd_rvalid_cyc1 got=%b exp=0", rv1); end
        checks++; if (rv2 !== 1'b1) begin failures++; $display("FAIL rd_rvalid_cyc2 got=%b exp=1", rv2); end
        checks++; if (rv3 !== 1'b0) begin failures++; $display("FAIL rd_rvalid_cyc3 got=%b exp=0", rv3); end
        checks++; if (d !== 16'h1F41) begin failures++; $display("FAIL rd_data0 got=%h exp=1f41", d); end
    endtask

    task automatic test_strobe();
        logic rv1, rv2, rv3; logic [15:0] d;
        do_write(5, 16'hAAAA, 2'b11);
        do_write(5, 16'h5555, 2'b01);
        do_read(5, rv1, rv2, rv3, d);
        checks++; if (d !== 16'hAA55) begin failures++; $display("FAIL strobe_lo got=%h exp=aa55", d); end
        do_write(5, 16'h1234, 2'b10);
        do_read(5, rv1, rv2, rv3, d);
        checks++; if (d !== 16'h1255) begin failures++; $display("FAIL strobe_hi got=%h exp=1255", d); end
    endtask

    task automatic test_clear();
        logic rv1, rv2, rv3; logic [15:0] d, e; int n, a; bit rb;
        pulse_cmd(1'b1, 1'b0);
        count_busy(-1, n, rb);
        m_clear();
        checks++; if (n !== CELLS) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", n, CELLS); end
        checks++; if (rb !== 1'b0) begin failures++; $display("FAIL clear_ready_low got=%b exp=0", rb); end
        do_read(0, rv1, rv2, rv3, d);
        checks++; if (d !== 16'h0720 || rv2 !== 1'b1) begin failures++; $display("FAIL clear_cell0 got=%h exp=0720", d); end
        do_read(CELLS - 1, rv1, rv2, rv3, d);
        checks++; if (d !== 16'h0720 || rv2 !== 1'b1) begin failures++; $display("FAIL clear_cell_last got=%h exp=0720", d); end
        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(0, CELLS - 1);
            do_read(a, rv1, rv2, rv3, d);
            e = m_read(a);
            checks++; if (d !== e) begin failures++; $display("FAIL clear_rand[%0d] got=%h exp=%h", a, d, e); end
        end
    endtask

    task automatic test_random_rw();
        logic rv1, rv2, rv3; logic [15:0] d, e; int a;
        // An out-of-range write must not alias onto a wrapped physical cell.
        do_write(CELLS + 5, 16'h1234, 2'b11);
        do_read(5, rv1, rv2, rv3, d);
        e = m_read(5);
        checks++; if (d !== e) begin failures++; $display("FAIL oor_write_alias got=%h exp=%h", d, e); end
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(CELLS, 8191)) : int'($urandom_range(0, CELLS - 1));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, 16'($urandom), 2'($urandom_range(0, 3)));
            end else begin
                do_read(a, rv1, rv2, rv3, d);
                if (m_known(a)) begin
                    e = m_read(a);
                    checks++; if (d !== e || rv2 !== 1'b1) begin failures++; $display("FAIL rand_rd[%0d] got=%h rv=%b exp=%h", a, d, rv2, e); end
                end
            end
        end
    endtask

    task automatic test_scroll();
        logic [15:0] d, e; int n, a; bit rb;
        do_write(80, 16'h0142, 2'b11);
        pulse_cmd(1'b0, 1'b1);
        count_busy(10, n, rb);
        m_scroll();
        checks++; if (n !== COLS) begin failures++; $display("FAIL scroll_busy_cycles got=%0d exp=%0d", n, COLS); end
        vid_read(0, d);
        checks++; if (d !== 16'h0142) begin failures++; $display("FAIL scroll_vid0 got=%h exp=0142", d); end
        for (int i = CELLS - COLS; i < CELLS; i++) begin
            vid_read(i, d);
            checks++; if (d !== 16'h0720) begin failures++; $display("FAIL scroll_bottom[%0d] got=%h exp=0720", i, d); end
        end
        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, CELLS - 1);
            vid_read(a, d);
            e = m_read(a);
            if (m_known(a)) begin
                checks++; if (d !== e) begin failures++; $display("FAIL vid_rand[%0d] got=%h exp=%h", a, d, e); end
            end
        end
        vid_read(CELLS + 100, d);
        checks++; if (d !== BLANK) begin failures++; $display("FAIL vid_oor got=%h exp=%h", d, BLANK); end
    endtask

    task automatic test_back_to_back();
        logic rv1, rv2, rv3; logic [15:0] d, e; int n; bit rb;
        // write then read of the same cell on consecutive cycles
        @(negedge clk);
        sys.sys_valid = 1'b1; sys.sys_we = 1'b1; sys.sys_addr = 13'd777;
        sys.sys_wdata = 16'hC3A5; sys.sys_wstrb = 2'b11;
        @(negedge clk);
        sys.sys_we = 1'b0;
        @(negedge clk);
        sys.sys_valid = 1'b0;
        @(negedge clk);
        m_write(777, 16'hC3A5, 2'b11);
        checks++; if (sys.sys_rdata !== 16'hC3A5 || sys.sys_rvalid !== 1'b1) begin failures++; $display("FAIL b2b_wr_rd got=%h rv=%b exp=c3a5", sys.sys_rdata, sys.sys_rvalid); end

        // write accepted together with cmd_scroll lands with the pre-scroll base
        @(negedge clk);
        sys.sys_valid = 1'b1; sys.sys_we = 1'b1; sys.sys_addr = 13'd100;
        sys.sys_wdata = 16'h6B6B; sys.sys_wstrb = 2'b11; cmd_scroll = 1'b1;
        @(negedge clk);
        sys.sys_valid = 1'b0; sys.sys_we = 1'b0; cmd_scroll = 1'b0;
        m_write(100, 16'h6B6B, 2'b11);
        m_scroll();
        count_busy(-1, n, rb);
        checks++; if (n !== COLS) begin failures++; $display("FAIL b2b_scroll_busy got=%0d exp=%0d", n, COLS); end
        do_read(20, rv1, rv2, rv3, d);
        e = m_read(20);
        checks++; if (d !== e) begin failures++; $display("FAIL wr_with_cmd got=%h exp=%h", d, e); end

        // video latency and read-before-write
        do_write(300, 16'h3030, 2'b11);
        do_write(310, 16'h3131, 2'b11);
        @(negedge clk); vid_addr = 13'd310;
        repeat (3) @(negedge clk);
        vid_addr = 13'd300;
        @(negedge clk);
        checks++; if (vid_data !== 16'h3131) begin failures++; $display("FAIL vid_latency_1cyc got=%h exp=3131", vid_data); end
        sys.sys_valid = 1'b1; sys.sys_we = 1'b1; sys.sys_addr = 13'd300;
        sys.sys_wdata = 16'hBEEF; sys.sys_wstrb = 2'b11;
        @(negedge clk);
        sys.sys_valid = 1'b0; sys.sys_we = 1'b0;
        m_write(300, 16'hBEEF, 2'b11);
        checks++; if (vid_data !== 16'h3030) begin failures++; $display("FAIL vid_rbw_old got=%h exp=3030", vid_data); end
        @(negedge clk);
        checks++; if (vid_data !== 16'hBEEF) begin failures++; $display("FAIL vid_rbw_new got=%h exp=beef", vid_data); end
    endtask

    task automatic test_scroll_wrap();
        logic rv1, rv2, rv3; logic [15:0] d, e; int n; bit rb, bad; int addrs [0:9];
        pulse_cmd(1'b1, 1'b0);
        count_busy(-1, n, rb);
        m_clear();
        bad = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            do_write(COLS + i, 16'(16'h4000 + i), 2'b11);
            pulse_cmd(1'b0, 1'b1);
            count_busy(-1, n, rb);
            m_scroll();
            if (n != COLS) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL wrap_busy_cycles got=%b exp=0", bad); end
        do_write(5, 16'h5A5A, 2'b11);
        addrs[0] = 5;
        for (int i = 1; i < 10; i++) begin
            addrs[i] = $urandom_range(0, CELLS - 1);
            do_write(addrs[i], 16'($urandom), 2'b11);
        end
        // Reset returns base to 0; contents stay put only if base had wrapped back to 0.
        @(negedge clk); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_read(addrs[i], rv1, rv2, rv3, d);
            e = m_read(addrs[i]);
            checks++; if (d !== e) begin failures++; $display("FAIL wrap_cell[%0d] got=%h exp=%h", addrs[i], d, e); end
        end
    endtask

    task automatic test_same_cycle_and_abort();
        logic rv1, rv2, rv3; logic [15:0] d, e; int n; bit rb;
        pulse_cmd(1'b1, 1'b1);
        count_busy(-1, n, rb);
        m_clear();
        checks++; if (n !== CELLS) begin failures++; $display("FAIL clr_scr_busy got=%0d exp=%0d", n, CELLS); end
        for (int i = 0; i < 10; i++) begin
            do_write(i, 16'(16'h2100 + i), 2'b11);
            do_write(200 + i, 16'(16'h2200 + i), 2'b11);
        end
        pulse_cmd(1'b1, 1'b0);
        repeat (99) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (sys.sys_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", sys.sys_ready); end
        @(negedge clk); resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            scr[i] = BLANK;
        end
        for (int i = 0; i < 10; i++) begin
            do_read(i, rv1, rv2, rv3, d);
            e = m_read(i);
            checks++; if (d !== e) begin failures++; $display("FAIL abort_filled[%0d] got=%h exp=%h", i, d, e); end
            do_read(200 + i, rv1, rv2, rv3, d);
            e = m_read(200 + i);
            checks++; if (d !== e) begin failures++; $display("FAIL abort_kept[%0d] got=%h exp=%h", 200 + i, d, e); end
        end
        do_read(CELLS, rv1, rv2, rv3, d);
        checks++; if (d !== 16'h0720 || rv2 !== 1'b1) begin failures++; $display("FAIL oor_read_lo got=%h exp=0720", d); end
        do_read(8191, rv1, rv2, rv3, d);
        checks++; if (d !== 16'h0720 || rv2 !== 1'b1) begin failures++; $display("FAIL oor_read_hi got=%h exp=0720", d); end
    endtask

    initial begin
        sys.sys_valid = 1'b0; sys.sys_we = 1'b0; sys.sys_addr = '0;
        sys.sys_wdata = '0; sys.sys_wstrb = '0;
        for (int i = 0; i < CELLS; i++) begin
            scr[i] = '0;
            known[i] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_strobe();
        test_clear();
        test_random_rw();
        test_scroll();
        test_back_to_back();
        test_scroll_wrap();
        test_same_cycle_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
